// File: rtl/count_down_pkg.sv
// count_down_pkg: shared state encoding, field limits and BCD helper for the countdown front panel
package count_down_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, EDIT_H = 2'd1, EDIT_M = 2'd2, EDIT_S = 2'd3} state_t;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
endpackage

// File: rtl/bcd_field_stepper.sv
// bcd_field_stepper: two-digit BCD register stepped by +/-1 with wrap between 00 and MAX
module bcd_field_stepper
  import count_down_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] value
);
  localparam logic [7:0] MAX_BCD = to_bcd(MAX);
  logic [3:0] hi, lo;
  assign hi = value[7:4];
  assign lo = value[3:0];
  // step one unit with BCD carry/borrow; simultaneous inc and dec cancel
  always_ff @(posedge clk) begin
    if (clear) value <= 8'h00;
    else if (inc && !dec) value <= value == MAX_BCD ? 8'h00 : lo == 4'd9 ? {hi + 4'd1, 4'd0} : {hi, lo + 4'd1};
    else if (dec && !inc) value <= value == 8'h00 ? MAX_BCD : lo == 4'd0 ? {hi - 4'd1, 4'd9} : {hi, lo - 4'd1};
  end
endmodule

// File: rtl/count_down_setter.sv
// count_down_setter: button-driven preset editor emitting BCD presets and set/play/stop pulses
module count_down_setter
  import count_down_pkg::*;
#(
  parameter int BLINK_DIV = 25_000_000,
  parameter int HOUR_MAX  = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       counting,
  output logic [7:0] hour_bcd_out,
  output logic [7:0] minute_bcd_out,
  output logic [7:0] second_bcd_out,
  output logic       set,
  output logic       play,
  output logic       stop,
  output logic [1:0] field_sel,
  output logic       blink
);
  localparam int CW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  state_t state, state_n;
  logic set_d, play_d, pend_d, pend, nonzero;
  logic inc_h, dec_h, inc_m, dec_m, inc_s, dec_s;
  logic [CW-1:0] cnt;
  assign field_sel = state;
  assign nonzero = |{hour_bcd_out, minute_bcd_out, second_bcd_out};
  bcd_field_stepper #(.MAX(HOUR_MAX)) u_hour (.clk(clk), .clear(rst), .inc(inc_h), .dec(dec_h), .value(hour_bcd_out));
  bcd_field_stepper #(.MAX(MIN_MAX)) u_minute (.clk(clk), .clear(rst), .inc(inc_m), .dec(dec_m), .value(minute_bcd_out));
  bcd_field_stepper #(.MAX(SEC_MAX)) u_second (.clk(clk), .clear(rst), .inc(inc_s), .dec(dec_s), .value(second_bcd_out));
  // decode buttons by priority stop > start > mode > up/down; a running timer locks the editor in IDLE
  always_comb begin
    state_n = state;
    set_d = 1'b0;
    play_d = 1'b0;
    pend_d = 1'b0;
    inc_h = 1'b0;
    dec_h = 1'b0;
    inc_m = 1'b0;
    dec_m = 1'b0;
    inc_s = 1'b0;
    dec_s = 1'b0;
    if (counting) state_n = IDLE;
    else if (!btn_stop) begin
      if (btn_start) begin
        state_n = IDLE;
        set_d = state != IDLE;
        play_d = state == IDLE && nonzero;
        pend_d = state != IDLE && nonzero;
      end else if (btn_mode) begin
        state_n = state_t'(state + 2'd1);
        set_d = state == EDIT_S;
      end else if (btn_up ^ btn_down) begin
        inc_h = btn_up && state == EDIT_H;
        dec_h = btn_down && state == EDIT_H;
        inc_m = btn_up && state == EDIT_M;
        dec_m = btn_down && state == EDIT_M;
        inc_s = btn_up && state == EDIT_S;
        dec_s = btn_down && state == EDIT_S;
      end
    end
  end
  // state and command pulses; a start from an edit field defers play one cycle behind set
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      set <= 1'b0;
      play <= 1'b0;
      stop <= 1'b0;
      pend <= 1'b0;
    end else begin
      state <= state_n;
      set <= set_d;
      play <= play_d || pend;
      stop <= btn_stop;
      pend <= pend_d;
    end
  end
  // blink phase restarts high on every field entry and toggles every BLINK_DIV cycles while editing
  always_ff @(posedge clk) begin
    if (rst || state_n == IDLE) begin
      cnt <= '0;
      blink <= 1'b0;
    end else if (state_n != state) begin
      cnt <= '0;
      blink <= 1'b1;
    end else if (cnt == CW'(BLINK_DIV - 1)) begin
      cnt <= '0;
      blink <= !blink;
    end else cnt <= cnt + 1'b1;
  end
endmodule

// File: tb/tb_count_down_setter.sv
// tb_count_down_setter: directed scenarios for the countdown preset editor
module tb_count_down_setter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_start = 1'b0, btn_stop = 1'b0, counting = 1'b0;
  logic [7:0] hour_bcd_out, minute_bcd_out, second_bcd_out;
  logic set, play, stop, blink;
  logic [1:0] field_sel;
  int total = 0;
  int bad = 0;
  count_down_setter #(.BLINK_DIV(4), .HOUR_MAX(23)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .btn_start(btn_start), .btn_stop(btn_stop), .counting(counting),
    .hour_bcd_out(hour_bcd_out), .minute_bcd_out(minute_bcd_out), .second_bcd_out(second_bcd_out),
    .set(set), .play(play), .stop(stop), .field_sel(field_sel), .blink(blink)
  );
  always #5 clk = ~clk;
  // b = {mode, up, down, start, stop}; returns on the falling edge after the capturing edge
  task automatic press(input logic [4:0] b);
    {btn_mode, btn_up, btn_down, btn_start, btn_stop} = b;
    @(negedge clk);
    {btn_mode, btn_up, btn_down, btn_start, btn_stop} = 5'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    total++;
    if ({hour_bcd_out, minute_bcd_out, second_bcd_out} !== 24'h000000) begin
      bad++;
      $display("FAIL reset_values got=%h exp=000000", {hour_bcd_out, minute_bcd_out, second_bcd_out});
    end
    total++;
    if ({set, play, stop, blink, field_sel} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=000000", {set, play, stop, blink, field_sel});
    end
  endtask
  task automatic test_hour_wrap();
    press(5'b10000);
    total++;
    if (field_sel !== 2'd1 || blink !== 1'b1) begin
      bad++;
      $display("FAIL enter_hour got sel=%0d blink=%b exp sel=1 blink=1", field_sel, blink);
    end
    repeat (25) press(5'b01000);
    total++;
    if (hour_bcd_out !== 8'h01) begin
      bad++;
      $display("FAIL hour_up_wrap got=%h exp=01", hour_bcd_out);
    end
    repeat (2) press(5'b00100);
    total++;
    if (hour_bcd_out !== 8'h23) begin
      bad++;
      $display("FAIL hour_down_wrap got=%h exp=23", hour_bcd_out);
    end
    press(5'b01100);
    total++;
    if (hour_bcd_out !== 8'h23) begin
      bad++;
      $display("FAIL hour_up_down got=%h exp=23", hour_bcd_out);
    end
    repeat (2) press(5'b01000);
  endtask
  task automatic test_min_wrap();
    press(5'b10000);
    press(5'b00100);
    total++;
    if (field_sel !== 2'd2 || minute_bcd_out !== 8'h59) begin
      bad++;
      $display("FAIL minute_down_wrap got sel=%0d min=%h exp sel=2 min=59", field_sel, minute_bcd_out);
    end
    press(5'b10000);
    total++;
    if (field_sel !== 2'd3 || set !== 1'b0) begin
      bad++;
      $display("FAIL enter_second got sel=%0d set=%b exp sel=3 set=0", field_sel, set);
    end
    press(5'b10000);
    total++;
    if (field_sel !== 2'd0 || set !== 1'b1 || blink !== 1'b0) begin
      bad++;
      $display("FAIL mode_commit got sel=%0d set=%b blink=%b exp sel=0 set=1 blink=0", field_sel, set, blink);
    end
    @(negedge clk);
    total++;
    if (set !== 1'b0 || play !== 1'b0) begin
      bad++;
      $display("FAIL mode_commit_after got set=%b play=%b exp 0 0", set, play);
    end
  endtask
  task automatic test_start_from_edit();
    press(5'b10000);
    press(5'b00100);
    press(5'b10000);
    repeat (2) press(5'b01000);
    press(5'b10000);
    repeat (30) press(5'b01000);
    total++;
    if ({hour_bcd_out, minute_bcd_out, second_bcd_out} !== 24'h000130) begin
      bad++;
      $display("FAIL preset got=%h exp=000130", {hour_bcd_out, minute_bcd_out, second_bcd_out});
    end
    press(5'b00010);
    total++;
    if ({set, play, field_sel} !== 4'b1000 || {hour_bcd_out, minute_bcd_out, second_bcd_out} !== 24'h000130) begin
      bad++;
      $display("FAIL start_set got set=%b play=%b sel=%0d val=%h exp 1 0 0 000130", set, play, field_sel, {hour_bcd_out, minute_bcd_out, second_bcd_out});
    end
    @(negedge clk);
    total++;
    if ({set, play} !== 2'b01) begin
      bad++;
      $display("FAIL start_play got set=%b play=%b exp 0 1", set, play);
    end
    @(negedge clk);
    total++;
    if (play !== 1'b0) begin
      bad++;
      $display("FAIL play_width got=%b exp=0", play);
    end
    press(5'b00010);
    total++;
    if ({set, play} !== 2'b01) begin
      bad++;
      $display("FAIL idle_start got set=%b play=%b exp 0 1", set, play);
    end
    @(negedge clk);
  endtask
  task automatic test_zero_preset();
    do_reset();
    press(5'b00010);
    total++;
    if (play !== 1'b0 || set !== 1'b0) begin
      bad++;
      $display("FAIL zero_start got play=%b set=%b exp 0 0", play, set);
    end
    @(negedge clk);
    total++;
    if (play !== 1'b0) begin
      bad++;
      $display("FAIL zero_start_late got=%b exp=0", play);
    end
    press(5'b00001);
    total++;
    if (stop !== 1'b1 || field_sel !== 2'd0) begin
      bad++;
      $display("FAIL idle_stop got stop=%b sel=%0d exp 1 0", stop, field_sel);
    end
    @(negedge clk);
    total++;
    if (stop !== 1'b0) begin
      bad++;
      $display("FAIL stop_width got=%b exp=0", stop);
    end
  endtask
  task automatic test_counting();
    press(5'b10000);
    press(5'b01000);
    counting = 1'b1;
    @(negedge clk);
    total++;
    if (field_sel !== 2'd0 || set !== 1'b0) begin
      bad++;
      $display("FAIL counting_abort got sel=%0d set=%b exp 0 0", field_sel, set);
    end
    press(5'b10000);
    press(5'b01000);
    press(5'b00010);
    total++;
    if (field_sel !== 2'd0 || hour_bcd_out !== 8'h01 || play !== 1'b0) begin
      bad++;
      $display("FAIL counting_lock got sel=%0d hour=%h play=%b exp 0 01 0", field_sel, hour_bcd_out, play);
    end
    counting = 1'b0;
    press(5'b00011);
    total++;
    if ({stop, play, set} !== 3'b100) begin
      bad++;
      $display("FAIL start_stop got stop=%b play=%b set=%b exp 1 0 0", stop, play, set);
    end
    @(negedge clk);
    total++;
    if (play !== 1'b0) begin
      bad++;
      $display("FAIL start_stop_late got play=%b exp 0", play);
    end
  endtask
  task automatic test_back_to_back();
    btn_stop = 1'b1;
    @(negedge clk);
    total++;
    if (stop !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first got=%b exp=1", stop);
    end
    @(negedge clk);
    btn_stop = 1'b0;
    total++;
    if (stop !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second got=%b exp=1", stop);
    end
    @(negedge clk);
    total++;
    if (stop !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end got=%b exp=0", stop);
    end
  endtask
  task automatic test_blink();
    do_reset();
    press(5'b10000);
    for (int i = 0; i < 9; i++) begin
      total++;
      if (blink !== ((i / 4) % 2 == 0)) begin
        bad++;
        $display("FAIL blink_seq[%0d] got=%b exp=%b", i, blink, (i / 4) % 2 == 0);
      end
      @(negedge clk);
    end
    press(5'b10000);
    total++;
    if (blink !== 1'b1 || field_sel !== 2'd2) begin
      bad++;
      $display("FAIL blink_restart got blink=%b sel=%0d exp 1 2", blink, field_sel);
    end
    press(5'b01000);
    rst = 1'b1;
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    rst = 1'b0;
    total++;
    if ({hour_bcd_out, minute_bcd_out, second_bcd_out, set, play, stop, blink, field_sel} !== 30'b0) begin
      bad++;
      $display("FAIL mid_reset got val=%h ctrl=%b exp 0", {hour_bcd_out, minute_bcd_out, second_bcd_out}, {set, play, stop, blink, field_sel});
    end
    @(negedge clk);
    total++;
    if ({set, play} !== 2'b00) begin
      bad++;
      $display("FAIL mid_reset_after got set=%b play=%b exp 0 0", set, play);
    end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_hour_wrap();
    test_min_wrap();
    test_start_from_edit();
    test_zero_preset();
    test_counting();
    test_back_to_back();
    test_blink();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
